cache_valid_ctrl: RTL
=====================

// Module: cache_valid_ctrl
// PURPOSE
//  Sequencing controller for one set-associative cache's valid-bit and tag arrays.
//  Accepts lookups and classifies each as hit or miss from the tag-compare vector.
//  On a miss it runs the memory refill handshake, picks a victim way and writes it valid.
//  Drives validWrite/decode/din for every way's valid-bit array; sits between the CPU port and memory.
// PARAMETERS
//  NUM_SETS  8  sets in the cache
//  SET_BITS  3  log2(NUM_SETS)
//  NUM_WAYS  4  ways per set
//  WAY_BITS  2  log2(NUM_WAYS)
// PORTS
//  clk            in   1         single clock; all state changes on its rising edge
//  reset          in   1         asynchronous, active-low; 0 clears all state immediately
//  req_valid      in   1         lookup request
//  req_ready      out  1         controller can accept a lookup
//  req_set        in   SET_BITS  set index of the request
//  hit_vec        in   NUM_WAYS  per-way tag match AND valid, for the latched set
//  valid_vec      in   NUM_WAYS  per-way valid bits, for the latched set
//  mem_req_valid  out  1         refill request to memory
//  mem_req_ready  in   1         memory accepted the refill request
//  mem_resp_valid in   1         refill data returned (1-cycle pulse)
//  valid_write    out  1         write strobe to the valid-bit arrays
//  tag_write      out  1         write strobe to the tag arrays
//  valid_set      out  SET_BITS  set index driven to the array decoders
//  valid_way      out  NUM_WAYS  one-hot (or all-ones on flush) way enable
//  valid_din      out  1         value written to the valid bits
//  resp_valid     out  1         lookup complete (1-cycle pulse)
//  resp_hit       out  1         1 = hit, 0 = miss that has been refilled
//  resp_way       out  WAY_BITS  way holding the line
//  flush_req      in   1         level request to invalidate the whole cache
//  flush_busy     out  1         flush sequence in progress
// BEHAVIOUR
//  Reset: state IDLE; every output 0; round-robin pointers 0; latched set 0; req_ready 0 while reset=0.
//  Outputs decode from registered state and registered latches; no input-to-output combinational path except req_ready.
//  IDLE: req_ready = !flush_req. A handshake (req_valid & req_ready) latches req_set -> LOOKUP.
//  LOOKUP (1 cycle): samples hit_vec/valid_vec.
//   - |hit_vec -> RESP, hit=1, way = lowest set bit of hit_vec.
//   - else -> MISS_REQ, victim = lowest invalid way; if none, rr_ptr[set].
//  MISS_REQ: mem_req_valid=1 and held until mem_req_ready=1 -> MISS_WAIT.
//  MISS_WAIT: waits for mem_resp_valid -> FILL. mem_resp_valid is ignored in all other states.
//  FILL (1 cycle): valid_write=1, tag_write=1, valid_din=1, valid_set=latched set, valid_way=onehot(victim).
//   - If the victim came from rr_ptr, rr_ptr[set] increments modulo NUM_WAYS (wraps at NUM_WAYS-1 -> 0).
//   - Next state -> RESP with hit=0.
//  RESP: resp_valid=1, resp_hit, resp_way valid for exactly this cycle -> IDLE.
//  Latency: hit is accept@0, resp_valid@2. Miss is resp_valid 2 cycles after mem_resp_valid.
//  Reset mid-operation: the sequence is abandoned with no partial write; the array state is owned by the arrays' own reset.
// CONFIGURATION
//  CACHE_VALID_FLUSH_EN defined:
//   - In IDLE, flush_req has priority over a simultaneous req_valid.
//   - FLUSH state: walks sets 0..NUM_SETS-1, one per cycle. Each cycle drives valid_write=1, valid_din=0, valid_way=all-ones.
//   - All rr_ptr are cleared. flush_busy=1 for exactly NUM_SETS cycles, then -> IDLE.
//   - A flush_req raised during a lookup waits until IDLE.
//  Not defined: flush_req is ignored, flush_busy is tied 0, and the FLUSH state does not exist. Ports are kept.
// STRUCTURE
//  Package cache_ctrl_pkg holds:
//   - state enum (IDLE, LOOKUP, MISS_REQ, MISS_WAIT, FILL, RESP, FLUSH)
//   - NUM_WAYS/SET_BITS/WAY_BITS localparam defaults
//   - onehot/priority-encode functions
//  Sub-module cache_victim_sel:
//   - holds the per-set rr_ptr array and the invalid-first victim pick
//   - advance and clear-all inputs
// TESTING
//  Reset release, req_valid=1 set=3, hit_vec=0100 -> resp_valid @ cycle 2, resp_hit=1, resp_way=2, valid_write never 1.
//  Miss set=5, valid_vec=1011, mem_req_ready after 3 cycles -> mem_req_valid held 3 cycles; FILL shows valid_way=0100, valid_set=5, resp_hit=0, resp_way=2.
//  Four misses to set 1 with valid_vec=1111 -> victims 0,1,2,3, then 0 on the fifth (wrap); set 2's pointer unchanged.
//  Drop reset during MISS_WAIT -> all outputs 0 at once; after release, req_ready=1 and a stale mem_resp_valid is ignored.
//  With CACHE_VALID_FLUSH_EN: flush_req and req_valid in the same cycle -> 8 writes, sets 0..7, valid_way=1111, din=0; then the lookup is accepted.
//  Without CACHE_VALID_FLUSH_EN: flush_req=1 for 20 cycles -> flush_busy=0, valid_write=0, and lookups proceed normally.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// Shared types and helpers for the cache valid-bit / tag-array controller.
// Holds the controller state encoding, the cache geometry and the
// one-hot / priority-encode helpers used by the controller and victim picker.
package cache_ctrl_pkg;

  localparam int NUM_SETS = 8;
  localparam int SET_BITS = 3;
  localparam int NUM_WAYS = 4;
  localparam int WAY_BITS = 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_REQ  = 3'd2,
    MISS_WAIT = 3'd3,
    FILL      = 3'd4,
    RESP      = 3'd5,
    FLUSH     = 3'd6
  } state_t;

  // Way index to one-hot way enable.
  function automatic logic [NUM_WAYS-1:0] onehot(input logic [WAY_BITS-1:0] way);
    logic [NUM_WAYS-1:0] v;
    v      = '0;
    v[way] = 1'b1;
    return v;
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [WAY_BITS-1:0] prio_enc(input logic [NUM_WAYS-1:0] vec);
    logic [WAY_BITS-1:0] idx;
    idx = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = WAY_BITS'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_victim_sel.sv
// Victim way selection for a miss.
// An invalid way is always preferred (lowest index first); when every way of
// the set is valid the per-set round-robin pointer chooses, and from_rr tells
// the controller that the pointer must advance once the fill is written.
module cache_victim_sel
  import cache_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [SET_BITS-1:0] set_idx,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic                advance,
  input  logic                clear_all,
  output logic [WAY_BITS-1:0] victim,
  output logic                from_rr
);

  logic [WAY_BITS-1:0] rr_ptr [NUM_SETS];

  // Per-set round-robin pointers; the WAY_BITS add wraps NUM_WAYS-1 back to 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else if (clear_all) begin
      for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
    end else if (advance) begin
      rr_ptr[set_idx] <= rr_ptr[set_idx] + 1'b1;
    end
  end

  // Invalid-first pick, falling back to the set's round-robin pointer.
  always_comb begin
    from_rr = &valid_vec;
    victim  = from_rr ? rr_ptr[set_idx] : prio_enc(~valid_vec);
  end

endmodule

// File: rtl/cache_valid_ctrl.sv
// Sequencing controller for a set-associative cache's valid-bit and tag arrays.
// Classifies each lookup as hit or miss, runs the memory refill handshake on a
// miss and writes the chosen victim way valid.
// Optional feature macro: CACHE_VALID_FLUSH_EN adds a whole-cache flush walk.
//
// Handshakes: a transfer happens on a rising edge where the valid and ready of
// the same channel are both 1 (req_valid/req_ready, mem_req_valid/mem_req_ready);
// a valid, once raised, holds until that edge. resp_valid and mem_resp_valid
// are single-cycle pulses with no back-pressure.
module cache_valid_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SET_BITS-1:0] req_set,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  input  logic                mem_resp_valid,
  output logic                valid_write,
  output logic                tag_write,
  output logic [SET_BITS-1:0] valid_set,
  output logic [NUM_WAYS-1:0] valid_way,
  output logic                valid_din,
  output logic                resp_valid,
  output logic                resp_hit,
  output logic [WAY_BITS-1:0] resp_way,
  input  logic                flush_req,
  output logic                flush_busy,
  output state_t              state_dbg
);

  state_t              state;
  logic [SET_BITS-1:0] set_q;
  logic [WAY_BITS-1:0] victim_q;
  logic                from_rr_q;
  logic [WAY_BITS-1:0] victim;
  logic                from_rr;
  logic                rr_advance;
  logic                rr_clear;

  assign state_dbg  = state;
  assign rr_advance = (state == FILL) && from_rr_q;

`ifdef CACHE_VALID_FLUSH_EN
  logic [SET_BITS-1:0] flush_cnt;

  assign rr_clear  = (state == FLUSH);
  // A pending flush blocks new lookups so it wins a same-cycle tie.
  assign req_ready = reset && (state == IDLE) && !flush_req;
`else
  logic unused_flush_req;

  assign unused_flush_req = flush_req;
  assign rr_clear         = 1'b0;
  assign flush_busy       = 1'b0;
  assign req_ready        = reset && (state == IDLE);
`endif

  cache_victim_sel u_victim_sel (
    .clk       (clk),
    .reset     (reset),
    .set_idx   (set_q),
    .valid_vec (valid_vec),
    .advance   (rr_advance),
    .clear_all (rr_clear),
    .victim    (victim),
    .from_rr   (from_rr)
  );

  // Controller FSM; every output is registered and set on the transition into its state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      set_q         <= '0;
      victim_q      <= '0;
      from_rr_q     <= 1'b0;
      mem_req_valid <= 1'b0;
      valid_write   <= 1'b0;
      tag_write     <= 1'b0;
      valid_set     <= '0;
      valid_way     <= '0;
      valid_din     <= 1'b0;
      resp_valid    <= 1'b0;
      resp_hit      <= 1'b0;
      resp_way      <= '0;
`ifdef CACHE_VALID_FLUSH_EN
      flush_cnt     <= '0;
      flush_busy    <= 1'b0;
`endif
    end else begin
      // Array strobes and response fields live for one cycle unless re-set below.
      valid_write <= 1'b0;
      tag_write   <= 1'b0;
      valid_set   <= '0;
      valid_way   <= '0;
      valid_din   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;

      case (state)
        IDLE: begin
`ifdef CACHE_VALID_FLUSH_EN
          if (flush_req) begin
            state       <= FLUSH;
            flush_cnt   <= '0;
            flush_busy  <= 1'b1;
            valid_write <= 1'b1;
            valid_way   <= '1;
            valid_set   <= '0;
          end else
`endif
          if (req_valid) begin
            set_q <= req_set;
            state <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (|hit_vec) begin
            resp_valid <= 1'b1;
            resp_hit   <= 1'b1;
            resp_way   <= prio_enc(hit_vec);
            state      <= RESP;
          end else begin
            victim_q      <= victim;
            from_rr_q     <= from_rr;
            mem_req_valid <= 1'b1;
            state         <= MISS_REQ;
          end
        end

        MISS_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MISS_WAIT;
          end
        end

        MISS_WAIT: begin
          if (mem_resp_valid) begin
            valid_write <= 1'b1;
            tag_write   <= 1'b1;
            valid_din   <= 1'b1;
            valid_set   <= set_q;
            valid_way   <= onehot(victim_q);
            state       <= FILL;
          end
        end

        FILL: begin
          resp_valid <= 1'b1;
          resp_hit   <= 1'b0;
          resp_way   <= victim_q;
          state      <= RESP;
        end

        RESP: begin
          state <= IDLE;
        end

`ifdef CACHE_VALID_FLUSH_EN
        FLUSH: begin
          if (flush_cnt == SET_BITS'(NUM_SETS - 1)) begin
            flush_busy <= 1'b0;
            state      <= IDLE;
          end else begin
            flush_cnt   <= flush_cnt + 1'b1;
            valid_write <= 1'b1;
            valid_way   <= '1;
            valid_set   <= flush_cnt + 1'b1;
          end
        end
`endif

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
